// File: rtl/sd_tx_fetch_pkg.sv
// Shared SD definitions used by the TX fetch engine: FIFO depth, Wishbone
// cycle-type encodings and the fetch sequencer state encoding.
package sd_defines;

    localparam int SD_FIFO_TX_DEPTH = 16;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_SPACE = 3'd1,
        ST_BURST      = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_DONE       = 3'd4,
        ST_ERR        = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/sd_tx_fetch.sv
// Wishbone burst-read engine that moves a block of words from system memory
// into the SD TX FIFO, throttled on the FIFO fill level.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start
// WAIT_SPACE | waiting until the FIFO can absorb the next burst
// BURST      | incrementing burst in flight, one FIFO write per ack
// SETTLE     | two cycles so the sampled level includes our own writes
// DONE       | all words written; done pulses on the way back to IDLE
// ERR        | bus error seen; one cycle then back to IDLE
module sd_tx_fetch
    import sd_defines::*;
#(
    parameter int BURST      = 4,
    parameter int FIFO_DEPTH = SD_FIFO_TX_DEPTH,
    parameter int LEN_W      = 16
) (
    input  logic             wclk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      start_adr,
    input  logic [LEN_W-1:0] xfer_words,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      m_wb_adr_o,
    output logic             m_wb_cyc_o,
    output logic             m_wb_stb_o,
    output logic             m_wb_we_o,
    output logic [3:0]       m_wb_sel_o,
    output logic [2:0]       m_wb_cti_o,
    output logic [1:0]       m_wb_bte_o,
    input  logic [31:0]      m_wb_dat_i,
    input  logic             m_wb_ack_i,
    input  logic             m_wb_err_i,
    output logic [31:0]      fifo_d,
    output logic             fifo_wr,
    input  logic             fifo_full,
    input  logic [5:0]       fifo_level
);

    localparam int BC_W = $clog2(BURST + 1);

    fetch_state_t     r_state;
    logic [31:0]      r_adr;
    logic [LEN_W-1:0] r_rem;
    logic [BC_W-1:0]  r_beat_cnt;
    logic             r_settle;
    logic [5:0]       r_lvl_q;
    logic             r_full_q;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_cyc;
    logic [2:0]       r_cti;
    logic [31:0]      r_fifo_d;
    logic             r_fifo_wr;

    logic [BC_W-1:0]  w_beats;
    logic [6:0]       w_free;
    logic             w_space_ok;
    logic             w_last_beat;

    // Size of the next burst and free FIFO space as seen through the sampled level
    always_comb begin
        w_beats = BC_W'(BURST);
        if (r_rem < LEN_W'(BURST)) begin
            w_beats = BC_W'(r_rem);
        end
        w_free = 7'd0;
        if ({1'b0, r_lvl_q} < 7'(FIFO_DEPTH)) begin
            w_free = 7'(FIFO_DEPTH) - {1'b0, r_lvl_q};
        end
    end

    assign w_space_ok  = (w_free >= 7'(w_beats)) && !r_full_q;
    assign w_last_beat = (r_beat_cnt == BC_W'(1));

    // Sample the FIFO level and full flag every cycle; a stale sample only under-reports space
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_lvl_q  <= '0;
            r_full_q <= 1'b0;
        end else begin
            r_lvl_q  <= fifo_level;
            r_full_q <= fifo_full;
        end
    end

    // Fetch sequencer: owns the bus master signals, the FIFO write port and the status flags
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_adr      <= '0;
            r_rem      <= '0;
            r_beat_cnt <= '0;
            r_settle   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cyc      <= 1'b0;
            r_cti      <= CTI_CLASSIC;
            r_fifo_d   <= '0;
            r_fifo_wr  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_fifo_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (xfer_words != '0) begin
                            r_adr   <= {start_adr[31:2], 2'b00};
                            r_rem   <= xfer_words;
                            r_state <= ST_WAIT_SPACE;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_space_ok) begin
                        r_cyc      <= 1'b1;
                        r_beat_cnt <= w_beats;
                        r_cti      <= (w_beats == BC_W'(1)) ? CTI_EOB : CTI_INCR;
                        r_state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (m_wb_err_i) begin
                        r_cyc   <= 1'b0;
                        r_cti   <= CTI_CLASSIC;
                        r_err   <= 1'b1;
                        r_state <= ST_ERR;
                    end else if (m_wb_ack_i) begin
                        r_fifo_d   <= m_wb_dat_i;
                        r_fifo_wr  <= 1'b1;
                        r_adr      <= r_adr + 32'd4;
                        r_beat_cnt <= r_beat_cnt - BC_W'(1);
                        if (r_rem != '0) begin
                            r_rem <= r_rem - LEN_W'(1);
                        end
                        if (abort) begin
                            r_cyc   <= 1'b0;
                            r_cti   <= CTI_CLASSIC;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (w_last_beat) begin
                            r_cyc    <= 1'b0;
                            r_cti    <= CTI_CLASSIC;
                            r_settle <= 1'b0;
                            r_state  <= ST_SETTLE;
                        end else begin
                            r_cti <= (r_beat_cnt == BC_W'(2)) ? CTI_EOB : CTI_INCR;
                        end
                    end else if (abort) begin
                        r_cyc   <= 1'b0;
                        r_cti   <= CTI_CLASSIC;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_settle) begin
                        r_state <= (r_rem == '0) ? ST_DONE : ST_WAIT_SPACE;
                    end else begin
                        r_settle <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign m_wb_adr_o = r_adr;
    assign m_wb_cyc_o = r_cyc;
    assign m_wb_stb_o = r_cyc;
    assign m_wb_we_o  = 1'b0;
    assign m_wb_sel_o = 4'hF;
    assign m_wb_cti_o = r_cti;
    assign m_wb_bte_o = 2'b00;
    assign fifo_d     = r_fifo_d;
    assign fifo_wr    = r_fifo_wr;

endmodule

// File: tb/tb_sd_tx_fetch.sv
// Bench for sd_tx_fetch: a Wishbone memory slave with optional wait-states
// and error injection, a table of transfers with hand-computed results, and
// directed sequences for throttling, bus error, abort and async reset.
module tb_sd_tx_fetch;

    typedef struct {
        logic [31:0] adr;
        int          words;
        logic [5:0]  level;
        bit          ws;
        int          exp_wr;
        int          bursts;
        logic [15:0] eob;
        logic [31:0] adr0;
    } vec_t;

    logic        wclk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_adr;
    logic [15:0] xfer_words;
    logic        abort;
    logic        busy, done, err;
    logic [31:0] m_wb_adr_o;
    logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o;
    logic [3:0]  m_wb_sel_o;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_ack_i, m_wb_err_i;
    logic [31:0] fifo_d;
    logic        fifo_wr;
    logic        fifo_full;
    logic [5:0]  fifo_level;

    bit          ws_en;
    int          err_at;

    int          cyc_n = 0;
    logic [31:0] ack_adr_q[$];
    logic [2:0]  ack_cti_q[$];
    logic [31:0] wr_q[$];
    int          wr_t_q[$];
    int          rise_q[$];
    int          done_cnt = 0;
    int          done_t = 0;
    int          err_t = 0;
    int          acks_total = 0;
    int          full_viol = 0;
    bit          ws_phase = 1'b0;
    bit          cyc_prev = 1'b0;

    int          n_chk = 0;
    int          n_err = 0;

    sd_tx_fetch dut (
        .wclk       (wclk),
        .rst        (rst),
        .start      (start),
        .start_adr  (start_adr),
        .xfer_words (xfer_words),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_cyc_o (m_wb_cyc_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_sel_o (m_wb_sel_o),
        .m_wb_cti_o (m_wb_cti_o),
        .m_wb_bte_o (m_wb_bte_o),
        .m_wb_dat_i (m_wb_dat_i),
        .m_wb_ack_i (m_wb_ack_i),
        .m_wb_err_i (m_wb_err_i),
        .fifo_d     (fifo_d),
        .fifo_wr    (fifo_wr),
        .fifo_full  (fifo_full),
        .fifo_level (fifo_level)
    );

    always #5 wclk = ~wclk;

    // Cycle counter, advanced on every active edge
    always @(posedge wclk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1111};
    endfunction

    // Memory slave response for the current cycle, then log what the DUT did in it
    always @(negedge wclk) begin
        m_wb_ack_i = 1'b0;
        m_wb_err_i = 1'b0;
        m_wb_dat_i = 32'h0;
        if (m_wb_cyc_o && m_wb_stb_o) begin
            if (ws_en && !ws_phase) begin
                ws_phase = 1'b1;
            end else begin
                ws_phase = 1'b0;
                if (acks_total == err_at) begin
                    m_wb_err_i = 1'b1;
                end else begin
                    m_wb_ack_i = 1'b1;
                    m_wb_dat_i = mem_word(m_wb_adr_o);
                end
            end
        end
        if (m_wb_ack_i) begin
            ack_adr_q.push_back(m_wb_adr_o);
            ack_cti_q.push_back(m_wb_cti_o);
            acks_total++;
        end
        if (m_wb_err_i) err_t = cyc_n;
        if (m_wb_cyc_o && !cyc_prev) rise_q.push_back(cyc_n);
        cyc_prev = m_wb_cyc_o;
        if (fifo_wr) begin
            wr_q.push_back(fifo_d);
            wr_t_q.push_back(cyc_n);
            if (fifo_full) full_viol++;
        end
        if (done) begin
            done_cnt++;
            done_t = cyc_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 400;
        while (busy && budget > 0) begin
            @(negedge wclk);
            budget--;
        end
        chk({name, "_busy_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_start(input logic [31:0] adr, input int words, output int t0);
        start_adr  = adr;
        xfer_words = 16'(words);
        @(negedge wclk);
        start = 1'b1;
        t0    = cyc_n;
        @(negedge wclk);
        start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          ab, wb, cb, dc, t0;
        logic [31:0] ea;
        string       p;
        p          = $sformatf("v%0d", idx);
        fifo_level = v.level;
        ws_en      = v.ws;
        ab = ack_adr_q.size();
        wb = wr_q.size();
        cb = rise_q.size();
        dc = done_cnt;
        pulse_start(v.adr, v.words, t0);
        chk({p, "_busy_t1"}, 32'(busy), 32'd1);
        chk({p, "_err_t1"}, 32'(err), 32'd0);
        wait_idle(p);
        repeat (3) @(negedge wclk);
        chk({p, "_acks"}, ack_adr_q.size() - ab, v.exp_wr);
        chk({p, "_writes"}, wr_q.size() - wb, v.exp_wr);
        chk({p, "_bursts"}, rise_q.size() - cb, v.bursts);
        chk({p, "_done_cnt"}, done_cnt - dc, 32'd1);
        for (int i = 0; i < v.exp_wr; i++) begin
            ea = v.adr0 + 32'(4 * i);
            if (ab + i < ack_adr_q.size()) begin
                chk($sformatf("%s_adr%0d", p, i), ack_adr_q[ab + i], ea);
                chk($sformatf("%s_cti%0d", p, i), 32'(ack_cti_q[ab + i]),
                    v.eob[i] ? 32'h7 : 32'h2);
            end
            if (wb + i < wr_q.size()) begin
                chk($sformatf("%s_data%0d", p, i), wr_q[wb + i], mem_word(ea));
            end
        end
        if (v.words == 0) begin
            chk({p, "_done_t"}, done_t - t0, 32'd2);
        end else begin
            if (rise_q.size() > cb) chk({p, "_cyc_t"}, rise_q[cb] - t0, 32'd2);
            if (wr_q.size() > wb) chk({p, "_done_lat"}, done_t - wr_t_q[wr_t_q.size() - 1], 32'd3);
        end
        chk({p, "_err_end"}, 32'(err), 32'd0);
    endtask

    initial begin
        vec_t vt [7];
        int   t0, tl, tb, wb, cb, ab, dc;

        //        adr            words lvl  ws  wr bursts eob       first adr
        vt[0] = '{32'h0000_1000, 8, 6'd0,  0, 8, 2, 16'h0088, 32'h0000_1000};
        vt[1] = '{32'h0000_2000, 6, 6'd0,  0, 6, 2, 16'h0028, 32'h0000_2000};
        vt[2] = '{32'h0000_3003, 1, 6'd0,  0, 1, 1, 16'h0001, 32'h0000_3000};
        vt[3] = '{32'hFFFF_FFF8, 3, 6'd0,  0, 3, 1, 16'h0004, 32'hFFFF_FFF8};
        vt[4] = '{32'h0000_5000, 0, 6'd0,  0, 0, 0, 16'h0000, 32'h0000_5000};
        vt[5] = '{32'h0000_6000, 5, 6'd10, 1, 5, 2, 16'h0018, 32'h0000_6000};
        vt[6] = '{32'h0000_7000, 4, 6'd12, 0, 4, 1, 16'h0008, 32'h0000_7000};

        rst        = 1'b1;
        start      = 1'b0;
        start_adr  = 32'h0;
        xfer_words = 16'h0;
        abort      = 1'b0;
        fifo_full  = 1'b0;
        fifo_level = 6'd0;
        ws_en      = 1'b0;
        err_at     = -1;

        repeat (2) @(negedge wclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cyc", 32'(m_wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(m_wb_stb_o), 32'd0);
        chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        chk("rst_adr", m_wb_adr_o, 32'd0);
        chk("rst_fifo_d", fifo_d, 32'd0);
        chk("rst_cti", 32'(m_wb_cti_o), 32'd0);
        chk("tie_we", 32'(m_wb_we_o), 32'd0);
        chk("tie_sel", 32'(m_wb_sel_o), 32'hF);
        chk("tie_bte", 32'(m_wb_bte_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge wclk);

        foreach (vt[i]) run_vec(i, vt[i]);

        // Throttle: 2 free words, then 3, then a full flag, then room
        ws_en      = 1'b0;
        fifo_level = 6'd14;
        cb = rise_q.size();
        wb = wr_q.size();
        dc = done_cnt;
        pulse_start(32'h0000_8000, 4, t0);
        repeat (6) @(negedge wclk);
        chk("thr_hold_lvl14", rise_q.size() - cb, 32'd0);
        fifo_level = 6'd13;
        repeat (4) @(negedge wclk);
        chk("thr_hold_lvl13", rise_q.size() - cb, 32'd0);
        fifo_level = 6'd12;
        fifo_full  = 1'b1;
        repeat (4) @(negedge wclk);
        chk("thr_hold_full", rise_q.size() - cb, 32'd0);
        fifo_full = 1'b0;
        tl = cyc_n;
        wait_idle("thr");
        repeat (3) @(negedge wclk);
        chk("thr_bursts", rise_q.size() - cb, 32'd1);
        if (rise_q.size() > cb) chk("thr_cyc_t", rise_q[cb] - tl, 32'd2);
        chk("thr_writes", wr_q.size() - wb, 32'd4);
        chk("thr_done", done_cnt - dc, 32'd1);
        fifo_level = 6'd0;

        // Bus error on the third beat
        wb = wr_q.size();
        dc = done_cnt;
        err_at = acks_total + 2;
        pulse_start(32'h0000_9000, 8, t0);
        wait_idle("berr");
        tb = cyc_n;
        err_at = -1;
        repeat (3) @(negedge wclk);
        chk("berr_flag", 32'(err), 32'd1);
        chk("berr_writes", wr_q.size() - wb, 32'd2);
        if (wr_q.size() > wb + 1) begin
            chk("berr_data0", wr_q[wb], mem_word(32'h0000_9000));
            chk("berr_data1", wr_q[wb + 1], mem_word(32'h0000_9004));
        end
        chk("berr_no_done", done_cnt - dc, 32'd0);
        chk("berr_busy_low_t", tb - err_t, 32'd2);
        run_vec(10, vt[2]);

        // Abort while waiting for FIFO space
        fifo_level = 6'd16;
        cb = rise_q.size();
        wb = wr_q.size();
        dc = done_cnt;
        pulse_start(32'h0000_A000, 4, t0);
        repeat (2) @(negedge wclk);
        abort = 1'b1;
        @(negedge wclk);
        abort = 1'b0;
        chk("abw_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge wclk);
        chk("abw_no_cyc", rise_q.size() - cb, 32'd0);
        chk("abw_no_wr", wr_q.size() - wb, 32'd0);
        chk("abw_no_done", done_cnt - dc, 32'd0);
        chk("abw_err", 32'(err), 32'd0);
        fifo_level = 6'd0;

        // Abort on the second beat, acked in the same cycle
        ab = ack_adr_q.size();
        wb = wr_q.size();
        dc = done_cnt;
        pulse_start(32'h0000_B000, 8, t0);
        @(negedge wclk);
        @(negedge wclk);
        abort = 1'b1;
        @(negedge wclk);
        abort = 1'b0;
        chk("abb_cyc", 32'(m_wb_cyc_o), 32'd0);
        chk("abb_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge wclk);
        chk("abb_acks", ack_adr_q.size() - ab, 32'd2);
        chk("abb_writes", wr_q.size() - wb, 32'd2);
        if (wr_q.size() > wb + 1) chk("abb_data1", wr_q[wb + 1], mem_word(32'h0000_B004));
        chk("abb_no_done", done_cnt - dc, 32'd0);
        chk("abb_err", 32'(err), 32'd0);

        // Asynchronous reset in the middle of a burst
        pulse_start(32'h0000_C000, 8, t0);
        @(negedge wclk);
        @(negedge wclk);
        chk("arst_cyc_before", 32'(m_wb_cyc_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_cyc", 32'(m_wb_cyc_o), 32'd0);
        chk("arst_stb", 32'(m_wb_stb_o), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge wclk);
        rst = 1'b0;
        repeat (3) @(negedge wclk);
        chk("arst_idle_cyc", 32'(m_wb_cyc_o), 32'd0);
        chk("arst_idle_busy", 32'(busy), 32'd0);

        chk("fifo_full_guard", full_viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
